instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage for the RISC-V core: owns the program counter, issues word fetches to instruction memory over a valid/ready request port and a response port, and hands fetched instructions (with their PC and opcode field) to the decode stage. It is the producer side of the opcode interface consumed by the main control decoder. It also consumes that decoder's branch/jump outcome as a PC redirect from execute.

## Interface
- PC_W, 32, program counter width in bits
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  fetch address, word aligned
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction word
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_instr  out  32  instruction word
- if_pc  out  PC_W  address of if_instr
- if_opcode  out  7  if_instr[6:0], feeds the control decoder
- redirect_valid  in  1  taken branch, JAL or JALR resolved in execute
- redirect_pc  in  PC_W  redirect target
- fetch_misalign  out  1  misaligned redirect trap (only with macro)

## Operation
- States: REQ (imem_req_valid=1), WAIT (one request outstanding), FULL (output register holds instruction, if_valid=1), DRAIN (stale request outstanding, response discarded), TRAP (macro only).
- At most one request outstanding or one instruction buffered at any time.
- REQ: request accepted when imem_req_valid && imem_req_ready, then go to WAIT. imem_req_addr = pc, held stable while valid.
- WAIT: on imem_rsp_valid, capture if_instr=imem_rsp_data and if_pc=pc, set pc=pc+4, then go to FULL. The response is not required to arrive on any particular cycle.
- FULL: on if_valid && if_ready, go to REQ.
- DRAIN: on imem_rsp_valid, discard the data and go to REQ.
- imem_rsp_valid is ignored in REQ and FULL.
- Redirect has highest priority in every state. It sets pc=redirect_pc and clears if_valid.
  - Next state is DRAIN if a request is outstanding: in WAIT, or in REQ with a request accepted that same cycle.
  - Otherwise next state is REQ.
- Redirect in FULL with if_ready high in the same cycle: the transfer counts as completed. Flushing decode is the consumer's job.
- pc+4 wraps modulo 2^PC_W. RESET_PC must be word aligned.

## Timing
- Reset values:
  - pc=RESET_PC, state=REQ
  - imem_req_valid=0 while reset is low
  - if_valid=0, if_instr=0, if_pc=0, if_opcode=0
  - fetch_misalign=0
- imem_req_valid rises the first cycle reset is high.
- Minimum latency: request accepted in cycle N, response in N+1, if_valid high in N+2. Best-case throughput is one instruction per 3 cycles.
- A redirect in cycle N causes imem_req_addr=redirect_pc with valid in N+1 when nothing is outstanding. Otherwise it issues one cycle after the stale response.
- if_instr, if_pc and if_opcode are registered and stable while if_valid && !if_ready.
- Reset asserted mid-operation abandons any outstanding request; memory must also reset.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=0 enters TRAP and sets fetch_misalign=1.
  - No further requests are issued, if_valid=0, and only reset exits.
  - If a request was outstanding, its response is discarded in TRAP.
- FETCH_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] is forced to 0, and fetch_misalign is tied 0.

## Structure
- Package fetch_pkg:
  - state enum (REQ, WAIT, FULL, DRAIN, TRAP)
  - INSTR_W=32
  - opcode constants R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, shared with the control decoder
- One sub-module, fetch_pc_gen, computes next PC: redirect target (aligned or trap check), else pc+4.

## Test plan
- Reset release, imem_req_ready=1, 1-cycle memory returning 0x00000013 -> requests to 0x0, 0x4, 0x8; if_pc=0x0 with if_valid in cycle 2.
- if_ready held low 5 cycles with FULL -> if_instr and if_pc stable, no new imem request issued.
- Redirect to 0x100 while in WAIT -> stale response dropped (if_valid stays 0), next request addr 0x100.
- Redirect to 0x40 while in FULL with if_ready=1 -> transfer completes, next request addr 0x40.
- PC_W=8, pc=0xFC -> next fetch 0x00 (wrap).
- Redirect to 0x102: with FETCH_MISALIGN_TRAP_EN, fetch_misalign=1 and no requests until reset; without it, request addr 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch stage state encoding, widths and RV32 opcode constants
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 7;

  typedef enum logic [2:0] {
    REQ   = 3'd0,
    WAIT  = 3'd1,
    FULL  = 3'd2,
    DRAIN = 3'd3,
    TRAP  = 3'd4
  } fetch_state_e;

  // Major opcodes shared with the main control decoder
  localparam logic [OPC_W-1:0] R_TYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] I_TYPE = 7'b0010011;
  localparam logic [OPC_W-1:0] LW     = 7'b0000011;
  localparam logic [OPC_W-1:0] SW     = 7'b0100011;
  localparam logic [OPC_W-1:0] BR     = 7'b1100011;
  localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] JALR   = 7'b1100111;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - next-PC select: redirect target or sequential pc+4
// FETCH_MISALIGN_TRAP_EN keeps the raw target and flags misalignment; otherwise the target is word-aligned.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] npc_o,
  output logic            misalign_o
);

  logic [PC_W-1:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc_i;
  assign misalign_o = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
  assign target     = redirect_pc_i & ~PC_W'(3);
  assign misalign_o = 1'b0;
`endif

  assign npc_o = redirect_valid_i ? target : pc_i + PC_W'(4);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V fetch stage: PC owner, single-outstanding imem fetch, decode output register
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [OPC_W-1:0]   if_opcode,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fetch_misalign
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    if_pc_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic               if_valid_q;
  logic               misalign_q;
  logic               misalign;
  logic               redirect_live;
  logic               req_fire;
  logic               pending;

  fetch_pc_gen #(.PC_W(PC_W)) u_pc_gen (
    .pc_i             (pc_q),
    .redirect_valid_i (redirect_live),
    .redirect_pc_i    (redirect_pc),
    .npc_o            (pc_d),
    .misalign_o       (misalign)
  );

  assign redirect_live  = redirect_valid && (state_q != TRAP);
  assign imem_req_valid = reset && (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A request is still in flight after this cycle unless its response lands now
  always_comb begin
    pending = 1'b0;
    case (state_q)
      REQ:         pending = req_fire;
      WAIT, DRAIN: pending = !imem_rsp_valid;
      default:     pending = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      misalign_q <= 1'b0;
    end else if (redirect_live) begin
      pc_q       <= pc_d;
      if_valid_q <= 1'b0;
      if (misalign) begin
        state_q    <= TRAP;
        misalign_q <= 1'b1;
      end else begin
        state_q <= pending ? DRAIN : REQ;
      end
    end else begin
      case (state_q)
        REQ: begin
          if (req_fire) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if_instr_q <= imem_rsp_data;
            if_pc_q    <= pc_q;
            pc_q       <= pc_d;
            if_valid_q <= 1'b1;
            state_q    <= FULL;
          end
        end
        FULL: begin
          if (if_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= REQ;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) state_q <= REQ;
        end
        default: ;
      endcase
    end
  end

  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_opcode      = if_instr_q[OPC_W-1:0];
  assign fetch_misalign = misalign_q;

endmodule
